// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// dmem_responder_pkg : shared types and constants for the data-memory responder
// Rev 1.0
// ============================================================================
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b10
    } data_type_t;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'b00,
        DMEM_WAIT = 2'b01,
        DMEM_RESP = 2'b10
    } dmem_state_t;

    localparam int unsigned DMEM_MAX_LATENCY = 15;
    localparam int          DMEM_CNT_W       = 4;

    // True when the access type is illegal or the offset breaks natural alignment.
    function automatic logic dmem_misaligned(input logic [1:0] dtype, input logic [1:0] off);
        logic bad;
        case (data_type_t'(dtype))
            BYTE:      bad = 1'b0;
            HALF_WORD: bad = off[0];
            WORD:      bad = (off != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// dmem_lane_align : byte-enable, store shift and load extract for one access
// Rev 1.0
// ============================================================================
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  data_type_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [4:0]  shamt;
    logic [31:0] rshift;

    assign shamt = {offset_i, 3'b000};

    always_comb begin
        be_o    = 4'b0000;
        rdata_o = 32'h0;
        wdata_o = wdata_i << shamt;
        rshift  = rword_i >> shamt;
        case (data_type_t'(data_type_i))
            BYTE: begin
                be_o    = 4'b0001 << offset_i;
                rdata_o = {24'h0, rshift[7:0]};
            end
            HALF_WORD: begin
                be_o    = 4'b0011 << offset_i;
                rdata_o = {16'h0, rshift[15:0]};
            end
            WORD: begin
                be_o    = 4'b1111;
                rdata_o = rshift;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : single-outstanding data memory with req/gnt/rvalid handshake
// Rev 1.0
// ============================================================================
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [1:0]  data_type_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int                    IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0]           ADDR_LIMIT = {1'b0, 32'(DEPTH)} << 2;
    localparam logic [DMEM_CNT_W-1:0] CNT_INIT   = DMEM_CNT_W'(LATENCY - 1);

    dmem_state_t           state_q, state_d;
    logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]      txn_idx_q, txn_idx_d;
    logic [1:0]            txn_off_q, txn_off_d;
    logic [1:0]            txn_dtype_q, txn_dtype_d;
    logic                  txn_we_q, txn_we_d;
    logic                  txn_err_q, txn_err_d;
    logic                  rvalid_q, rvalid_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic             req_err;
    logic [IDX_W-1:0] sel_idx;
    logic [1:0]       sel_off, sel_dtype;
    logic             sel_we, sel_err;
    logic [3:0]       be;
    logic [31:0]      wdata_sh, load_data;

    assign gnt_o   = rst_n && req_i && (state_q == DMEM_IDLE || state_q == DMEM_RESP);
    assign req_err = ({1'b0, addr_i} >= ADDR_LIMIT) || dmem_misaligned(data_type_i, addr_i[1:0]);

    // A grant can only coincide with entry to RESP when LATENCY is 1, so the
    // live request steers the lanes then; otherwise the latched transaction does.
    assign sel_idx   = gnt_o ? addr_i[IDX_W+1:2] : txn_idx_q;
    assign sel_off   = gnt_o ? addr_i[1:0]       : txn_off_q;
    assign sel_dtype = gnt_o ? data_type_i       : txn_dtype_q;
    assign sel_we    = gnt_o ? we_i              : txn_we_q;
    assign sel_err   = gnt_o ? req_err           : txn_err_q;

    dmem_lane_align u_lane_align (
        .data_type_i (sel_dtype),
        .offset_i    (sel_off),
        .wdata_i     (wdata_i),
        .rword_i     (mem[sel_idx]),
        .be_o        (be),
        .wdata_o     (wdata_sh),
        .rdata_o     (load_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        txn_idx_d   = txn_idx_q;
        txn_off_d   = txn_off_q;
        txn_dtype_d = txn_dtype_q;
        txn_we_d    = txn_we_q;
        txn_err_d   = txn_err_q;
        case (state_q)
            DMEM_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= DMEM_CNT_W'(1)) state_d = DMEM_RESP;
            end
            DMEM_RESP: state_d = DMEM_IDLE;
            default:   ;
        endcase
        if (gnt_o) begin
            state_d     = (LATENCY == 1) ? DMEM_RESP : DMEM_WAIT;
            cnt_d       = CNT_INIT;
            txn_idx_d   = addr_i[IDX_W+1:2];
            txn_off_d   = addr_i[1:0];
            txn_dtype_d = data_type_i;
            txn_we_d    = we_i;
            txn_err_d   = req_err;
        end
        rvalid_d = (state_d == DMEM_RESP);
        err_d    = rvalid_d && sel_err;
        rdata_d  = (rvalid_d && !sel_err && !sel_we) ? load_data : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DMEM_IDLE;
            cnt_q       <= '0;
            txn_idx_q   <= '0;
            txn_off_q   <= '0;
            txn_dtype_q <= '0;
            txn_we_q    <= 1'b0;
            txn_err_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            txn_idx_q   <= txn_idx_d;
            txn_off_q   <= txn_off_d;
            txn_dtype_q <= txn_dtype_d;
            txn_we_q    <= txn_we_d;
            txn_err_q   <= txn_err_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Storage is deliberately outside the reset domain; stores commit at the grant edge.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (gnt_o && we_i && !req_err && be[b]) begin
                mem[sel_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// tb_dmem_responder : scoreboard bench for LATENCY=1 and LATENCY=3 responders
// Rev 1.0
// ============================================================================
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int DEPTH = 1024;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    logic        rst_n   [2];
    logic        req     [2];
    logic        gnt     [2];
    logic [31:0] addr_s  [2];
    logic        we_s    [2];
    logic [1:0]  dt_s    [2];
    logic [31:0] wdata_s [2];
    logic        rvalid  [2];
    logic [31:0] rdata   [2];
    logic        err     [2];

    int          checks = 0;
    int          errors = 0;
    int          last_grant [2];
    exp_t        sb0 [$];
    exp_t        sb1 [$];
    logic [7:0]  mem_m [longint];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n[0]), .req_i(req[0]), .gnt_o(gnt[0]),
        .addr_i(addr_s[0]), .we_i(we_s[0]), .data_type_i(dt_s[0]), .wdata_i(wdata_s[0]),
        .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst_n(rst_n[1]), .req_i(req[1]), .gnt_o(gnt[1]),
        .addr_i(addr_s[1]), .we_i(we_s[1]), .data_type_i(dt_s[1]), .wdata_i(wdata_s[1]),
        .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1])
    );

    function automatic int lat_of(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic longint key(int d, logic [31:0] a);
        return longint'({32'(d), a});
    endfunction

    function automatic logic model_err(logic [31:0] a, logic [1:0] dt);
        if (a >= 32'(4 * DEPTH)) return 1'b1;
        if (dt == 2'b11) return 1'b1;
        if (dt == 2'b01 && (a % 2) != 0) return 1'b1;
        if (dt == 2'b10 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void push(int d, exp_t e);
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endfunction

    function automatic int sb_size(int d);
        return (d == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic exp_t pop(int d);
        if (d == 0) return sb0.pop_front();
        return sb1.pop_front();
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @cyc %0d", name, act, expv, cyc);
        end
    endtask

    task automatic monitor(int d);
        exp_t e;
        if (!rst_n[d]) begin
            check($sformatf("reset_outputs d%0d", d),
                  {rdata[d], 29'b0, rvalid[d], err[d], gnt[d]}, 64'h0);
        end else if (rvalid[d]) begin
            if (sb_size(d) == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid d%0d actual=1 expected=0 @cyc %0d", d, cyc);
            end else begin
                e = pop(d);
                check($sformatf("rdata d%0d", d), 64'(rdata[d]), 64'(e.rdata));
                check($sformatf("err d%0d", d), 64'(err[d]), 64'(e.err));
                check($sformatf("resp_cycle d%0d", d), 64'(cyc), 64'(e.due));
            end
        end else begin
            check($sformatf("idle_zero d%0d", d), {31'b0, err[d], rdata[d]}, 64'h0);
        end
    endtask

    always @(negedge clk) monitor(0);
    always @(negedge clk) monitor(1);

    // Drives one request from the posedge+1 phase and returns at the posedge+1 after its grant.
    task automatic issue(int d, logic we, logic [1:0] dt, logic [31:0] a, logic [31:0] wd);
        int          start, gc, exp_gc, n;
        logic        granted, e_err;
        logic [31:0] r;
        exp_t        e;
        start      = cyc;
        granted    = 1'b0;
        req[d]     = 1'b1;
        we_s[d]    = we;
        dt_s[d]    = dt;
        addr_s[d]  = a;
        wdata_s[d] = wd;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (gnt[d]) begin
                granted = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!granted) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout d%0d actual=no_grant expected=grant a=%h", d, a);
        end else begin
            gc     = cyc;
            exp_gc = (start > last_grant[d] + lat_of(d)) ? start : last_grant[d] + lat_of(d);
            check($sformatf("grant_cycle d%0d a=%h", d, a), 64'(gc), 64'(exp_gc));
            n     = 1 << dt;
            e_err = model_err(a, dt);
            r     = 32'h0;
            if (!e_err && we) begin
                for (int i = 0; i < n; i++) mem_m[key(d, a + 32'(i))] = 8'(wd >> (8 * i));
            end else if (!e_err) begin
                for (int i = 0; i < n; i++)
                    if (mem_m.exists(key(d, a + 32'(i))))
                        r |= 32'(mem_m[key(d, a + 32'(i))]) << (8 * i);
            end
            e.rdata = r;
            e.err   = e_err;
            e.due   = gc + lat_of(d);
            push(d, e);
            last_grant[d] = gc;
        end
        @(posedge clk);
        #1;
        req[d]     = 1'b0;
        addr_s[d]  = $urandom;
        we_s[d]    = 1'($urandom);
        dt_s[d]    = 2'($urandom);
        wdata_s[d] = $urandom;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic random_phase(int d);
        logic [31:0] a;
        logic [1:0]  dt;
        int          r;
        for (int w = 0; w < 16; w++) issue(d, 1'b1, WORD, 32'(w * 4), $urandom);
        repeat (60) begin
            r  = $urandom_range(0, 9);
            dt = (r == 1) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = (r == 0) ? 32'h4000 + $urandom_range(0, 255) : 32'($urandom_range(0, 63));
            if (dt != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << dt) - 32'd1);
            issue(d, 1'($urandom_range(0, 1)), dt, a, $urandom);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req[d] = 1'b0; addr_s[d] = '0; we_s[d] = 1'b0;
            dt_s[d] = '0; wdata_s[d] = '0; last_grant[d] = -100;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        issue(0, 1'b1, WORD, 32'h10, 32'hDEADBEEF);
        issue(0, 1'b0, WORD, 32'h10, 32'h0);
        issue(0, 1'b1, BYTE, 32'h13, 32'hAB);
        issue(0, 1'b0, WORD, 32'h10, 32'h0);
        issue(0, 1'b0, HALF_WORD, 32'h12, 32'h0);
        issue(0, 1'b0, BYTE, 32'h11, 32'h0);
        issue(0, 1'b1, HALF_WORD, 32'h11, 32'h1234);
        issue(0, 1'b0, WORD, 32'h10, 32'h0);
        issue(0, 1'b0, WORD, 32'h4000, 32'h0);
        issue(0, 1'b0, 2'b11, 32'h10, 32'h0);
        issue(0, 1'b1, WORD, 32'h3FFC, 32'hCAFEF00D);
        issue(0, 1'b0, WORD, 32'h3FFC, 32'h0);
        issue(0, 1'b1, HALF_WORD, 32'h3FFE, 32'h5A5A);
        issue(0, 1'b0, HALF_WORD, 32'h3FFE, 32'h0);
        for (int i = 0; i < 4; i++) issue(0, 1'b1, WORD, 32'(i * 4), 32'h11111111 * 32'(i + 1));
        idle(2);
        for (int i = 0; i < 4; i++) issue(0, 1'b0, WORD, 32'(i * 4), 32'h0);
        idle(2);
        random_phase(0);

        random_phase(1);
        idle(4);
        issue(1, 1'b0, WORD, 32'h10, 32'h0);
        issue(1, 1'b0, WORD, 32'h14, 32'h0);
        idle(5);
        issue(1, 1'b1, WORD, 32'h20, 32'h55);
        rst_n[1] = 1'b0;
        req[1]   = 1'b1;
        sb1.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n[1]      = 1'b1;
        req[1]        = 1'b0;
        last_grant[1] = -100;
        idle(4);
        issue(1, 1'b0, WORD, 32'h20, 32'h0);

        idle(10);
        check("sb_drain d0", 64'(sb0.size()), 64'h0);
        check("sb_drain d1", 64'(sb1.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the core's load/store request interface.
- Serves one outstanding transaction with a req/gnt/rvalid handshake.
- Performs byte-lane placement for BYTE/HALF_WORD/WORD accesses (`data_type_t`) and signals access faults.
- Used as the data memory in core-level simulation and FPGA builds, behind the core's LSU.

Parameters:
- DEPTH, 1024, number of 32-bit words in storage; valid byte addresses are 0 .. 4*DEPTH-1.
- LATENCY, 1, cycles from grant edge to rvalid_o; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_i  in  1  request valid from the core.
- gnt_o  out  1  request accepted this cycle (combinational).
- addr_i  in  32  byte address.
- we_i  in  1  1 = store, 0 = load.
- data_type_i  in  2  `data_type_t` (BYTE, HALF_WORD, WORD); 2'b11 is illegal.
- wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rvalid_o  out  1  response valid, one-cycle pulse per granted request.
- rdata_o  out  32  load data, right-aligned and zero-extended (the core performs sign extension); 0 for stores and errors.
- err_o  out  1  access fault, qualified by rvalid_o.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0.
  - rvalid_o=0, rdata_o=0, err_o=0, gnt_o=0.
  - Storage contents are not reset.
  - A pending transaction is dropped and never responded to.
  - A store granted before reset stays committed.
- FSM states: IDLE, WAIT, RESP.
- gnt_o = req_i && (state==IDLE || state==RESP). gnt_o is forced 0 while rst_n=0.
- On a grant edge:
  - Latch addr_i, we_i, data_type_i.
  - Compute err.
  - Counter loads LATENCY-1.
  - Next state is RESP if LATENCY==1, else WAIT.
- WAIT: counter decrements each cycle. When counter reaches 1, next state is RESP.
- RESP: rvalid_o=1 for exactly one cycle, exactly LATENCY cycles after the grant edge. Next state:
  - a grant in the same cycle restarts the sequence (back-to-back);
  - otherwise IDLE.
- Throughput: with LATENCY=1 and req_i held, one grant and one response per cycle.
- Error detection (evaluated at grant):
  - addr_i >= 4*DEPTH;
  - HALF_WORD with addr_i[0]=1;
  - WORD with addr_i[1:0]!=0;
  - data_type_i==2'b11.
  - On error: no storage write, rdata_o=0, err_o=1 on the response cycle.
- Stores: written at the grant edge. Byte enables:
  - BYTE: 1 << addr[1:0];
  - HALF_WORD: 2'b11 << addr[1:0];
  - WORD: 4'b1111.
  - wdata_i is shifted left by 8*addr[1:0] before writing.
- Loads: word at addr[31:2] (word index) is read on the edge that raises rvalid_o. It is shifted right by 8*addr[1:0] and masked to 8, 16 or 32 bits.
- A store granted in the same cycle as an earlier load's RESP does not affect that load's rdata_o.
- req_i while in WAIT: gnt_o=0. The core must hold the request; its inputs are don't-care until granted.
- rdata_o and err_o hold their values only during rvalid_o. Outside rvalid_o they return to 0.

Decomposition:
- Add to core_pkg:
  - `dmem_state_t` enum (DMEM_IDLE, DMEM_WAIT, DMEM_RESP);
  - `localparam DMEM_MAX_LATENCY = 15`.
- Reuse the existing `data_type_t`.
- One sub-module, `dmem_lane_align`: combinational byte-enable generation, store shift and load extract/mask, driven by data_type and addr[1:0]. Keep the FSM, counter and storage in the top module.
- Error causes map onto the existing EXC_CAUSE_LOAD_FAULT / EXC_CAUSE_STORE_FAULT in the core. No new causes.

Test Plan:
- LATENCY=1: SW 0xDEADBEEF @0x10, then LW @0x10 -> gnt same cycle as req; rvalid_o 1 cycle after each grant; rdata_o=0xDEADBEEF; err_o=0.
- SB 0xAB @0x13, then LW @0x10 -> 0xABADBEEF. LH @0x12 -> 0x0000ABAD. LB @0x11 -> 0x000000BE.
- SH 0x1234 @0x11 -> err_o=1 and rdata_o=0 on the response; a following LW @0x10 is unchanged. LW @0x4000 with DEPTH=1024 -> err_o=1. data_type=2'b11 -> err_o=1.
- LATENCY=3: req held 1 cycle -> rvalid_o exactly 3 cycles after the grant. Second req during WAIT -> gnt_o=0 until the RESP cycle, then granted.
- LATENCY=1: req_i held 4 cycles with LW @0x0,0x4,0x8,0xC -> 4 consecutive grants and 4 consecutive rvalid pulses with matching data order.
- LATENCY=3: SW 0x55 @0x20 granted, rst_n low on the next cycle -> no rvalid_o; all outputs 0 during reset. After release, LW @0x20 -> 0x00000055.
